// File: rtl/branch_target_buffer_pkg.sv
// Shared types and helpers for the branch target buffer.
//   btbState_        : sweep FSM states (idle / invalidate sweep)
//   btbEntry_        : one BTB entry; tag and target are stored zero-extended
//                      to the package XLEN, counter to BTB_MAX_COUNTER_BITS
//   sat_counter_next : saturating up/down step of a direction counter
package branch_target_buffer_pkg;

  localparam int XLEN                 = 32;
  localparam int BTB_MAX_COUNTER_BITS = 4;

  typedef enum logic {
    BTB_IDLE,
    BTB_FLUSH
  } btbState_;

  typedef struct packed {
    logic                            valid;
    logic [XLEN-1:0]                 tag;
    logic [XLEN-1:0]                 target;
    logic [BTB_MAX_COUNTER_BITS-1:0] counter;
  } btbEntry_;

  // Counter holds 0..2^bits-1; bits above 'bits' stay zero because the
  // value can never step past the ceiling.
  function automatic logic [BTB_MAX_COUNTER_BITS-1:0] sat_counter_next(
    input logic [BTB_MAX_COUNTER_BITS-1:0] cnt,
    input logic                            up,
    input int                              bits
  );
    logic [BTB_MAX_COUNTER_BITS-1:0] ceiling;
    ceiling = BTB_MAX_COUNTER_BITS'((1 << bits) - 1);
    if (up && (cnt != ceiling))
      return cnt + BTB_MAX_COUNTER_BITS'(1);
    else if (!up && (cnt != '0))
      return cnt - BTB_MAX_COUNTER_BITS'(1);
    else
      return cnt;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, a multi-cycle invalidate sweep and a saturating mispredict count.
// Ports:
//   clock, reset (async, active low)
//   lookupPC/lookupValid           : fetch-side query (combinational answer)
//   branchPredictValid/Data        : predict-taken flag and target to Fetch
//   updateValid/PC/Taken/Target    : resolved control transfer from Execute
//   updateMispredict               : Fetch prediction for this update was wrong
//   flushRequest / flushBusy       : start / in-progress of invalidate sweep
//   mispredictCount                : saturating mispredict statistic
module branch_target_buffer #(
  parameter int XLEN         = 32,
  parameter int ENTRIES      = 16,
  parameter int COUNTER_BITS = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [XLEN-1:0]        lookupPC,
  input  logic                   lookupValid,
  output logic                   branchPredictValid,
  output logic [XLEN-1:0]        branchPredictData,
  input  logic                   updateValid,
  input  logic [XLEN-1:0]        updatePC,
  input  logic                   updateTaken,
  input  logic [XLEN-1:0]        updateTarget,
  input  logic                   updateMispredict,
  input  logic                   flushRequest,
  output logic                   flushBusy,
  output logic [COUNT_WIDTH-1:0] mispredictCount
);
  import branch_target_buffer_pkg::*;

  localparam int PKG_XLEN   = branch_target_buffer_pkg::XLEN;
  localparam int CTR_W      = BTB_MAX_COUNTER_BITS;
  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_W      = XLEN - INDEX_BITS - 2;

  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("ENTRIES must be a power of 2 and at least 2");
  end
  if ((COUNTER_BITS < 1) || (COUNTER_BITS > CTR_W)) begin : g_bad_counter
    $error("COUNTER_BITS must be in 1..4");
  end
  if (XLEN > PKG_XLEN) begin : g_bad_xlen
    $error("XLEN exceeds the entry field width");
  end

  btbEntry_                mem [ENTRIES];
  btbState_                state_q, state_d;
  logic [INDEX_BITS-1:0]   sweep_idx;
  logic [COUNT_WIDTH-1:0]  count_q;

  logic [INDEX_BITS-1:0]   lk_idx, up_idx;
  logic [PKG_XLEN-1:0]     lk_tag, up_tag;
  btbEntry_                lk_entry, up_entry, alloc_entry;
  logic                    lk_hit, up_hit, up_en;

  // Byte offset within a word never affects indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookupPC[1:0], updatePC[1:0]};

  assign lk_idx = lookupPC[INDEX_BITS+1:2];
  assign up_idx = updatePC[INDEX_BITS+1:2];

  always_comb begin
    lk_tag             = '0;
    lk_tag[TAG_W-1:0]  = lookupPC[XLEN-1:INDEX_BITS+2];
    lk_entry           = mem[lk_idx];
    lk_hit             = lookupValid && (state_q == BTB_IDLE) &&
                         lk_entry.valid && (lk_entry.tag == lk_tag);
    branchPredictValid = lk_hit && lk_entry.counter[COUNTER_BITS-1];
    branchPredictData  = branchPredictValid ? lk_entry.target[XLEN-1:0] : '0;
  end

  always_comb begin
    up_tag                         = '0;
    up_tag[TAG_W-1:0]              = updatePC[XLEN-1:INDEX_BITS+2];
    up_entry                       = mem[up_idx];
    up_hit                         = up_entry.valid && (up_entry.tag == up_tag);
    // A pending flush request takes priority over a simultaneous update.
    up_en                          = updateValid && !flushRequest &&
                                     (state_q == BTB_IDLE);
    alloc_entry                    = '0;
    alloc_entry.valid              = 1'b1;
    alloc_entry.tag                = up_tag;
    alloc_entry.target[XLEN-1:0]   = updateTarget;
    alloc_entry.counter            = CTR_W'(1) << (COUNTER_BITS - 1);
  end

  // All storage writes live in this one block so it can become an SRAM later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else if (state_q == BTB_FLUSH) begin
      mem[sweep_idx].valid <= 1'b0;
    end else if (up_en) begin
      if (up_hit) begin
        mem[up_idx].counter <= sat_counter_next(up_entry.counter, updateTaken,
                                                COUNTER_BITS);
        if (updateTaken) mem[up_idx].target[XLEN-1:0] <= updateTarget;
      end else if (updateTaken) begin
        mem[up_idx] <= alloc_entry;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= BTB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BTB_IDLE:  if (flushRequest) state_d = BTB_FLUSH;
      BTB_FLUSH: if (sweep_idx == INDEX_BITS'(ENTRIES - 1)) state_d = BTB_IDLE;
      default:   state_d = BTB_IDLE;
    endcase
  end

  // Sweep index sits at 0 while idle and wraps back to 0 after the last entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   sweep_idx <= '0;
    else if (state_q == BTB_FLUSH) sweep_idx <= sweep_idx + INDEX_BITS'(1);
    else                          sweep_idx <= '0;
  end

  // Counted in every state, including during a sweep.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count_q <= '0;
    else if (updateValid && updateMispredict && (count_q != '1))
      count_q <= count_q + COUNT_WIDTH'(1);
  end

  assign flushBusy       = (state_q == BTB_FLUSH);
  assign mispredictCount = count_q;

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised, direct-mapped branch target buffer with per-entry saturating direction counters.
- Replaces the stub BranchPredictor and drives the branchPredictData/branchPredictValid pair into Fetch.
- Trained by resolved control transfers from Execute.
- Supports a multi-cycle invalidate sweep, for fence.i or context change, and keeps a saturating mispredict statistic.

Parameters:
- XLEN, 32, address/target width.
- ENTRIES, 16, number of entries; power of 2, at least 2.
- COUNTER_BITS, 2, direction counter width; range 1..4.
- COUNT_WIDTH, 16, mispredict statistic width.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- lookupPC  input  XLEN  fetch PC being predicted.
- lookupValid  input  1  lookupPC is meaningful this cycle.
- branchPredictValid  output  1  predict taken this cycle.
- branchPredictData  output  XLEN  predicted target.
- updateValid  input  1  resolved control transfer from Execute this cycle.
- updatePC  input  XLEN  PC of the resolved instruction.
- updateTaken  input  1  actual direction.
- updateTarget  input  XLEN  actual target.
- updateMispredict  input  1  Fetch prediction was wrong.
- flushRequest  input  1  start invalidate sweep.
- flushBusy  output  1  sweep in progress.
- mispredictCount  output  COUNT_WIDTH  saturating mispredict count.

Behaviour:
- Indexing: INDEX_BITS = log2(ENTRIES).
  - index = pc[INDEX_BITS+1:2].
  - tag = pc[XLEN-1:INDEX_BITS+2].
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target, counter.
- Reset (reset low, asynchronous):
  - All entry fields cleared to 0.
  - State IDLE; sweep index 0; mispredictCount 0.
  - Consequently branchPredictValid=0, branchPredictData=0, flushBusy=0.
- Lookup (combinational from registered storage, zero latency):
  - hit = lookupValid & state==IDLE & valid[index] & tag match.
  - branchPredictValid = hit & counter MSB.
  - branchPredictData = target[index] when branchPredictValid, else 0.
- Update (sequential; applies only in IDLE with updateValid=1 and flushRequest=0):
  - No same-cycle bypass: an update becomes visible to lookups the next cycle.
  - Tag hit: counter increments on taken, decrements on not-taken, saturating at 0 and 2^COUNTER_BITS-1. Target is rewritten with updateTarget when taken.
  - Tag miss and taken: allocate (overwrite) the entry with valid=1, new tag, updateTarget, and counter=2^(COUNTER_BITS-1) (weakly taken).
  - Tag miss and not taken: no change.
- FSM states: IDLE, FLUSH.
  - IDLE to FLUSH on flushRequest; sweep index loads 0; flushBusy goes high the next cycle.
  - In FLUSH, each cycle clears valid[sweep index] and increments the index.
  - After clearing index ENTRIES-1 the FSM returns to IDLE, so flushBusy is high for exactly ENTRIES cycles.
  - While in FLUSH: lookups miss, updates are dropped, and further flushRequest is ignored.
- Simultaneous events:
  - flushRequest together with updateValid in IDLE: flush wins and the update is dropped.
  - Lookup and update on the same index in one cycle: the lookup sees pre-update contents.
- mispredictCount:
  - Increments on updateValid & updateMispredict in any state, including FLUSH.
  - Saturates at all-ones; cleared only by reset.
- Reset asserted mid-sweep: immediate return to IDLE with all entries cleared.
- Elaboration-time assertions: ENTRIES is a power of 2 and at least 2; COUNTER_BITS is in 1..4.

Decomposition:
- pack gains:
  - btbState_ enum {BTB_IDLE, BTB_FLUSH}.
  - btbEntry_ packed struct (valid, tag, target, counter), sized by package constants XLEN and BTB_MAX_COUNTER_BITS.
  - A saturating-counter next-value function.
- No sub-module: storage is flop arrays inside the block.
- The storage read/write stays in one always_ff so it can later be swapped for an SRAM macro.

Test Plan (ENTRIES=16, COUNTER_BITS=2, COUNT_WIDTH=4):
- Release reset; lookup 0x100 -> branchPredictValid=0, branchPredictData=0, flushBusy=0, mispredictCount=0.
- Update PC 0x100 taken, target 0x200; next cycle lookup 0x100 -> valid=1, data=0x200 (counter 10). The same-cycle lookup in the update cycle -> valid=0.
- Counter training on 0x100:
  - Two not-taken updates -> counter 00, lookup valid=0.
  - Three taken updates -> counter 11; a fourth taken update keeps it at 11.
  - One not-taken update -> counter 10, still predicts 0x200.
  - A not-taken update to miss PC 0x180 -> lookup 0x180 stays invalid.
- Aliasing: after 0x100 is trained, taken update 0x140 with target 0x300 (same index 0, different tag):
  - lookup 0x100 -> miss.
  - lookup 0x140 -> valid, data=0x300.
- Flush: populate indices 0, 5, 15, then pulse flushRequest for 1 cycle, plus a second pulse mid-sweep.
  - flushBusy is high exactly 16 cycles.
  - Lookups return valid=0 throughout.
  - A taken update to 0x20 during the sweep is dropped.
  - After the sweep, all lookups miss.
- Statistics and reset: 17 mispredict updates, 3 of them during FLUSH -> mispredictCount=15 (saturated). Drive reset low mid-sweep -> flushBusy=0 and count=0 immediately, without waiting for a clock edge.
